// File: rtl/dispatch_pkg.sv
// Shared definitions for the instruction dispatch controller: FSM state
// encoding, opcode values, executor unit indices and the opcode decoder.
package dispatch_pkg;

  localparam int NUM_UNITS = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FETCH  = 3'd4
  } state_e;

  localparam logic [3:0] OP_ALU   = 4'h0;
  localparam logic [3:0] OP_ALUI  = 4'h1;
  localparam logic [3:0] OP_MOVE  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;

  localparam logic [IDX_W-1:0] U_ALU   = 2'd0;
  localparam logic [IDX_W-1:0] U_MOVE  = 2'd1;
  localparam logic [IDX_W-1:0] U_LOAD  = 2'd2;
  localparam logic [IDX_W-1:0] U_STORE = 2'd3;

  typedef struct packed {
    logic             legal;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Map an opcode to its executor; anything unlisted is undecodable.
  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    d = '{legal: 1'b1, idx: U_ALU};
    case (op)
      OP_ALU, OP_ALUI: d.idx = U_ALU;
      OP_MOVE:         d.idx = U_MOVE;
      OP_LOAD:         d.idx = U_LOAD;
      OP_STORE:        d.idx = U_STORE;
      default:         d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// Saturating WAIT-cycle counter; flags expiry once TO_CYCLES-1 WAIT
// cycles have already elapsed, i.e. during the TO_CYCLES-th WAIT cycle.
module dispatch_watchdog #(
  parameter int TO_CYCLES = 63,
  parameter int CNT_W     = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_VAL = CNT_W'(TO_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear on WAIT entry, count each WAIT cycle, hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                          cnt_d = '0;
    else if (enable && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == EXP_VAL);

endmodule

// File: rtl/op_dispatch_ctrl.sv
// Instruction dispatch controller: decodes the opcode, pulses the start of
// one executor, waits for its done, then requests the next instruction.
// Optional watchdog abort of the WAIT state: define OP_DISPATCH_TIMEOUT_EN.
module op_dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int TO_CYCLES = 63,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          instruction,
  input  logic                 instr_valid,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic                 busy,
  output logic                 fetch_req,
  output logic                 illegal,
  output logic                 timeout
);

  // Reject configurations where the abort point cannot be reached.
  if (TO_CYCLES < 2 || TO_CYCLES > (1 << CNT_W) - 1) begin : g_bad_param
    $error("op_dispatch_ctrl: TO_CYCLES out of range for CNT_W");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             wd_expired;
  dec_t             dec;
  logic             unused_instr;

  // Only the opcode field matters here.
  assign unused_instr = ^instruction[11:0];
  assign dec          = decode_op(instruction[15:12]);

`ifdef OP_DISPATCH_TIMEOUT_EN
  dispatch_watchdog #(
    .TO_CYCLES (TO_CYCLES),
    .CNT_W     (CNT_W)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == ST_START),
    .enable  (state_q == ST_WAIT),
    .expired (wd_expired)
  );
`else
  // No watchdog: WAIT is left only by the matching done.
  assign wd_expired = 1'b0;
`endif

  // Next-state logic; flags are set only on the edge entering FETCH so they
  // are high exactly for the FETCH cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec.legal) begin
          idx_d   = dec.idx;
          state_d = ST_START;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_START:  state_d = ST_WAIT;
      ST_WAIT: begin
        // Matching done wins over a coincident watchdog expiry.
        if (unit_done[idx_q]) begin
          state_d = ST_FETCH;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, latched unit index and one-cycle flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore outputs from registered state and flags only.
  assign busy       = (state_q != ST_IDLE);
  assign fetch_req  = (state_q == ST_FETCH);
  assign unit_start = (state_q == ST_START) ? (NUM_UNITS'(1) << idx_q) : '0;
  assign illegal    = illegal_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_op_dispatch_ctrl.sv
// Self-checking bench for op_dispatch_ctrl. Expected outputs come from a
// transaction-level timeline: decode in cycle 1, start or illegal fetch in
// cycle 2, WAIT from cycle 3 until the done (or watchdog) cycle, then one
// FETCH cycle and back to idle.
module tb_op_dispatch_ctrl;

  localparam int TO = 63;
`ifdef OP_DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [3:0]  unit_done;
  logic [3:0]  unit_start;
  logic        busy, fetch_req, illegal, timeout;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  op_dispatch_ctrl #(.TO_CYCLES(TO), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .unit_done   (unit_done),
    .unit_start  (unit_start),
    .busy        (busy),
    .fetch_req   (fetch_req),
    .illegal     (illegal),
    .timeout     (timeout)
  );

  // Output bundle: {busy, unit_start[3:0], fetch_req, illegal, timeout}.
  function automatic logic [7:0] obs();
    return {busy, unit_start, fetch_req, illegal, timeout};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction from idle to idle. dcyc: WAIT cycle (1-based) carrying
  // the matching done, 0 = never. rcyc: WAIT cycle with rst asserted, 0 = none.
  task automatic txn(input logic [3:0] op, input int dcyc, input int rcyc,
                     input string nm);
    logic       legal;
    logic [3:0] oh;
    logic [7:0] exp;
    bit         done_now, to_now;
    legal = (op <= 4'd4);
    oh    = 4'b0000;
    if (legal) oh[(op <= 4'd1) ? 0 : int'(op) - 1] = 1'b1;

    instruction = {op, 12'($urandom)};
    instr_valid = 1'b1;
    unit_done   = 4'($urandom);
    step();                                   // cycle 1: decode
    exp = 8'b1_0000_000;
    checks++;
    if (obs() !== exp) begin
      errs++; $display("FAIL %s.decode: got %b want %b", nm, obs(), exp);
    end
    instr_valid = 1'($urandom);
    unit_done   = 4'($urandom);
    step();                                   // cycle 2: start or illegal fetch
    exp = legal ? {1'b1, oh, 3'b000} : 8'b1_0000_110;
    checks++;
    if (obs() !== exp) begin
      errs++; $display("FAIL %s.cycle2: got %b want %b", nm, obs(), exp);
    end

    if (!legal) begin
      instr_valid = 1'($urandom);
      step();
      instr_valid = 1'b0; unit_done = 4'b0;
      exp = 8'b0;
      checks++;
      if (obs() !== exp) begin
        errs++; $display("FAIL %s.idle: got %b want %b", nm, obs(), exp);
      end
      return;
    end

    instr_valid = 1'($urandom);
    unit_done   = 4'($urandom);               // done during start is ignored
    step();                                   // WAIT cycle 1
    for (int w = 1; w <= 300; w++) begin
      exp = 8'b1_0000_000;
      checks++;
      if (obs() !== exp) begin
        errs++; $display("FAIL %s.wait%0d: got %b want %b", nm, w, obs(), exp);
      end
      done_now    = (w == dcyc);
      to_now      = TO_EN && (w == TO) && !done_now;
      instr_valid = 1'($urandom);
      unit_done   = done_now ? (4'($urandom) | oh) : (4'($urandom) & ~oh);
      rst         = (w == rcyc);
      step();
      if (w == rcyc) begin
        rst = 1'b0; instr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
          exp = 8'b0;
          checks++;
          if (obs() !== exp) begin
            errs++; $display("FAIL %s.after_rst%0d: got %b want %b", nm, k, obs(), exp);
          end
          unit_done = oh;                     // late done must not fetch
          step();
        end
        unit_done = 4'b0;
        return;
      end
      if (done_now || to_now) begin
        exp = {1'b1, 4'b0000, 1'b1, 1'b0, to_now};
        checks++;
        if (obs() !== exp) begin
          errs++; $display("FAIL %s.fetch: got %b want %b", nm, obs(), exp);
        end
        instr_valid = 1'($urandom);
        unit_done   = 4'($urandom);
        step();
        instr_valid = 1'b0; unit_done = 4'b0;
        exp = 8'b0;
        checks++;
        if (obs() !== exp) begin
          errs++; $display("FAIL %s.idle: got %b want %b", nm, obs(), exp);
        end
        return;
      end
    end
    checks++; errs++;
    $display("FAIL %s.no_completion: got busy=%b want idle within 300 cycles", nm, busy);
    rst = 1'b1; step(); rst = 1'b0; instr_valid = 1'b0; unit_done = 4'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b1; unit_done = 4'hF; instruction = 16'h1000;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (obs() !== 8'b0) begin
        errs++; $display("FAIL reset%0d: got %b want %b", k, obs(), 8'b0);
      end
    end
    rst = 1'b0; instr_valid = 1'b0; unit_done = 4'b0;
    step();
    checks++;
    if (obs() !== 8'b0) begin
      errs++; $display("FAIL reset_release: got %b want %b", obs(), 8'b0);
    end
  endtask

  task automatic test_alu();         txn(4'h1, 3, 0, "alu");     txn(4'h0, 1, 0, "alu0"); endtask
  task automatic test_illegal();
    txn(4'hF, 0, 0, "illegal_f");
    for (int i = 5; i < 15; i++) txn(4'(i), 0, 0, "illegal_op");
  endtask
  task automatic test_other_done();  txn(4'h3, 6, 0, "load");  txn(4'h2, 2, 0, "move");  endtask
  task automatic test_reset_wait();  txn(4'h4, 5, 3, "rst_wait"); txn(4'h4, 3, 3, "rst_vs_done"); endtask

  task automatic test_watchdog();
`ifdef OP_DISPATCH_TIMEOUT_EN
    txn(4'h2, 0,  0, "timeout");
    txn(4'h3, TO, 0, "done_at_limit");
    txn(4'h0, TO + 1, 0, "timeout_first");
`else
    txn(4'h4, 201, 0, "no_timeout_200");
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    int         d, r;
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      d  = $urandom_range(1, 8);
      r  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, d) : 0;
      txn(op, d, r, "rand");
    end
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; unit_done = 4'b0; instruction = 16'h0;
    test_reset();
    test_alu();
    test_illegal();
    test_other_done();
    test_reset_wait();
    test_watchdog();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/op_dispatch_ctrl.md
OP_DISPATCH_CTRL -- requirements
Module: op_dispatch_ctrl

Interface
REQ-001 SHALL provide parameter TO_CYCLES, default 63, meaning the maximum WAIT cycles before watchdog abort (range 2..63).
REQ-002 SHALL provide parameter CNT_W, default 6, meaning the watchdog counter width.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port instruction  input  16  current instruction word; opcode is [15:12].
REQ-006 SHALL have port instr_valid  input  1  instruction register holds a new word.
REQ-007 SHALL have port unit_done  input  4  one done pulse per executor FSM: [0] ALU/ALUi, [1] move, [2] load, [3] store.
REQ-008 SHALL have port unit_start  output  4  one-hot, one-cycle start pulse to the selected executor.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port fetch_req  output  1  one-cycle request for the next instruction.
REQ-011 SHALL have port illegal  output  1  one-cycle flag: undecodable opcode.
REQ-012 SHALL have port timeout  output  1  one-cycle flag: watchdog abort.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, DECODE, START, WAIT and FETCH; all outputs decode from the registered state and registered flags only.
REQ-014 SHALL go IDLE->DECODE on an edge where instr_valid=1; instr_valid SHALL be ignored in all other states.
REQ-015 SHALL latch opcode into a unit index in DECODE: 0000/0001->0, 0010->1, 0011->2, 0100->3; all other opcodes illegal.
REQ-016 SHALL go DECODE->START for a legal opcode; DECODE->FETCH with illegal=1 during that FETCH cycle for an illegal one.
REQ-017 SHALL drive in START unit_start = one-hot of the latched index for exactly one cycle, then go to WAIT.
REQ-018 SHALL go WAIT->FETCH on the first edge where unit_done[index]=1; done bits of other units and any done during START SHALL be ignored.
REQ-019 SHALL drive fetch_req=1 for exactly one cycle in FETCH, then go to IDLE.
REQ-020 SHALL have the following latency: instr_valid sampled at edge k; unit_start high in cycle k+2; done sampled at edge m; fetch_req high in cycle m+1; IDLE in cycle m+2.
REQ-021 SHALL run the watchdog counter as follows: cleared on WAIT entry, +1 per WAIT cycle, saturating at 2^CNT_W-1.
REQ-022 SHALL go WAIT->FETCH with timeout=1 during that FETCH cycle when the counter equals TO_CYCLES-1 with no matching done.
REQ-023 SHALL take the done path (timeout stays 0) if done and the timeout condition coincide.
REQ-024 SHALL never assert illegal and timeout together; unit_start SHALL have at most one bit set.

Reset
REQ-025 SHALL, on rst=1 at an edge, go to IDLE, clear the counter, latched index and flags, and drive all outputs to 0, regardless of the current state.
REQ-026 SHALL give rst priority over instr_valid and unit_done on the same edge, including reset mid-WAIT; no fetch_req follows an aborted instruction.

Configuration
REQ-027 SHALL, with macro OP_DISPATCH_TIMEOUT_EN defined, include the watchdog per REQ-021 to REQ-023.
REQ-028 SHALL, without OP_DISPATCH_TIMEOUT_EN, omit the counter, hold WAIT indefinitely until done, and tie timeout to 0.

Structure
REQ-029 SHALL define in shared package dispatch_pkg: the state encoding, opcode constants, unit index constants and the unit count (4).
REQ-030 SHALL place the watchdog counter in sub-module dispatch_watchdog (inputs clear/enable; output expired), instantiated only under OP_DISPATCH_TIMEOUT_EN.

Verification
REQ-031 SHALL cover: opcode 0001, instr_valid at edge 0, unit_done[0] 3 cycles after start -> unit_start=0001 in cycle 2, fetch_req one cycle after done, busy low afterwards.
REQ-032 SHALL cover: opcode 1111 -> no unit_start, illegal=1 and fetch_req=1 in cycle 2, IDLE in cycle 3.
REQ-033 SHALL cover: opcode 0011 with unit_done=0001 pulsed in WAIT -> ignored; unit_done=0100 later -> fetch_req.
REQ-034 SHALL cover, with OP_DISPATCH_TIMEOUT_EN and TO_CYCLES=63: no done -> timeout=1 and fetch_req=1 after 63 WAIT cycles; done on cycle 63 -> fetch_req with timeout=0.
REQ-035 SHALL cover: rst=1 during WAIT with opcode 0100 -> next cycle all outputs 0, IDLE; done arriving later causes no fetch_req.
REQ-036 SHALL cover, without OP_DISPATCH_TIMEOUT_EN: 200 cycles without done -> remains busy, timeout never asserts.
